// File: rtl/memory_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : memory_bus_arbiter_if
// Purpose  : Bundles the two master ports (CPU = M0, display = M1) and the
//            single-port main-memory bus seen by memory_bus_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface memory_bus_arbiter_if;
    // CPU data port (M0)
    logic        m0_req;
    logic [31:0] m0_addr;
    logic        m0_we;
    logic [3:0]  m0_be;
    logic [31:0] m0_wdata;
    logic        m0_ack;
    logic [31:0] m0_rdata;
    // Display scanout/fetch port (M1)
    logic        m1_req;
    logic [31:0] m1_addr;
    logic        m1_we;
    logic [3:0]  m1_be;
    logic [31:0] m1_wdata;
    logic        m1_ack;
    logic [31:0] m1_rdata;
    logic        m1_urgent;
    // Main-memory bus
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    // Status
    logic        busy;
    logic        owner;

    // Arbiter view: takes requests, drives acks and the memory strobe
    modport slave (
        input  m0_req, m0_addr, m0_we, m0_be, m0_wdata,
        output m0_ack, m0_rdata,
        input  m1_req, m1_addr, m1_we, m1_be, m1_wdata, m1_urgent,
        output m1_ack, m1_rdata,
        output mem_en, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_rdata,
        output busy, owner
    );

    // Environment view: masters plus the memory itself
    modport master (
        output m0_req, m0_addr, m0_we, m0_be, m0_wdata,
        input  m0_ack, m0_rdata,
        output m1_req, m1_addr, m1_we, m1_be, m1_wdata, m1_urgent,
        input  m1_ack, m1_rdata,
        input  mem_en, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_rdata,
        input  busy, owner
    );
endinterface
`default_nettype wire

// File: rtl/memory_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : memory_bus_arbiter
// Purpose  : Shares one single-port main-memory bus between the CPU (M0) and
//            the display engine (M1). One transaction at a time, round-robin
//            with a display-urgent override and a CPU anti-starvation limit.
//            Fixed-latency reads, writes acknowledged one cycle after issue.
// Revision : 1.0 - initial release
// ============================================================================
module memory_bus_arbiter #(
    parameter int MEM_LATENCY  = 2,   // 1..15
    parameter int STARVE_LIMIT = 4    // 1..15
) (
    input  wire                 clk,
    input  wire                 reset,   // asynchronous, active-low
    memory_bus_arbiter_if.slave bus
);

    localparam logic [3:0] LAT_LOAD   = 4'(MEM_LATENCY - 1);
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        owner_q, owner_d;             // visible grant, 0 out of reset
    logic        last_owner_q, last_owner_d;   // tie-break history, 1 out of reset
    logic [3:0]  starve_cnt_q, starve_cnt_d;
    logic [3:0]  lat_cnt_q, lat_cnt_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] m0_rdata_q, m0_rdata_d;
    logic [31:0] m1_rdata_q, m1_rdata_d;
    logic        grant_m1;

    // State and datapath registers; reset also drops any in-flight read
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            starve_cnt_q <= '0;
            lat_cnt_q    <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_be_q     <= '0;
            mem_wdata_q  <= '0;
            m0_rdata_q   <= '0;
            m1_rdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            starve_cnt_q <= starve_cnt_d;
            lat_cnt_q    <= lat_cnt_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_be_q     <= mem_be_d;
            mem_wdata_q  <= mem_wdata_d;
            m0_rdata_q   <= m0_rdata_d;
            m1_rdata_q   <= m1_rdata_d;
        end
    end

    // Next-state: arbitration in IDLE, latency countdown and read capture in WAIT
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        starve_cnt_d = starve_cnt_q;
        lat_cnt_d    = lat_cnt_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_be_d     = mem_be_q;
        mem_wdata_d  = mem_wdata_q;
        m0_rdata_d   = m0_rdata_q;
        m1_rdata_d   = m1_rdata_q;
        grant_m1     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.m0_req || bus.m1_req) begin
                    if (bus.m0_req && bus.m1_req) begin
                        // Starvation guard outranks urgency, urgency outranks fairness
                        if (starve_cnt_q == STARVE_MAX) begin
                            grant_m1 = 1'b0;
                        end else if (bus.m1_urgent) begin
                            grant_m1 = 1'b1;
                        end else begin
                            grant_m1 = ~last_owner_q;
                        end
                    end else begin
                        grant_m1 = bus.m1_req;
                    end

                    owner_d      = grant_m1;
                    last_owner_d = grant_m1;
                    state_d      = ST_ISSUE;

                    if (grant_m1) begin
                        mem_we_d    = bus.m1_we;
                        mem_addr_d  = bus.m1_addr;
                        mem_be_d    = bus.m1_be;
                        mem_wdata_d = bus.m1_wdata;
                        // Only a CPU that was actually waiting counts as a loss
                        if (bus.m0_req && (starve_cnt_q != STARVE_MAX)) begin
                            starve_cnt_d = starve_cnt_q + 4'd1;
                        end
                    end else begin
                        mem_we_d     = bus.m0_we;
                        mem_addr_d   = bus.m0_addr;
                        mem_be_d     = bus.m0_be;
                        mem_wdata_d  = bus.m0_wdata;
                        starve_cnt_d = '0;
                    end
                end
            end

            ST_ISSUE: begin
                if (mem_we_q) begin
                    state_d = ST_RESP;
                end else begin
                    state_d   = ST_WAIT;
                    lat_cnt_d = LAT_LOAD;
                end
            end

            ST_WAIT: begin
                if (lat_cnt_q == 4'd0) begin
                    if (owner_q) begin
                        m1_rdata_d = bus.mem_rdata;
                    end else begin
                        m0_rdata_d = bus.mem_rdata;
                    end
                    state_d = ST_RESP;
                end else begin
                    lat_cnt_d = lat_cnt_q - 4'd1;
                end
            end

            ST_RESP: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs decode directly from registered state so nothing glitches
    assign bus.mem_en    = (state_q == ST_ISSUE);
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.m0_ack    = (state_q == ST_RESP) && !owner_q;
    assign bus.m1_ack    = (state_q == ST_RESP) &&  owner_q;
    assign bus.m0_rdata  = m0_rdata_q;
    assign bus.m1_rdata  = m1_rdata_q;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.owner     = owner_q;

endmodule
`default_nettype wire

// File: tb/tb_memory_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_memory_bus_arbiter
// Purpose  : Self-checking bench for memory_bus_arbiter. One DUT at the
//            default latency carries most scenarios; two more instances at
//            MEM_LATENCY=1 and 15 cover the latency extremes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_memory_bus_arbiter;

    typedef struct {
        int          inst;      // 0 = main DUT, 1 = latency 1, 2 = latency 15
        bit          master;
        logic [31:0] addr;
        logic [31:0] rdata;
        bit          chk_rdata;
        int          cyc;       // expected ack cycle, -1 = not checked
    } exp_t;

    logic clk;
    logic reset;
    int   n_total;
    int   n_bad;
    exp_t sb[$];

    memory_bus_arbiter_if b();
    memory_bus_arbiter_if b1();
    memory_bus_arbiter_if b15();

    memory_bus_arbiter #(.MEM_LATENCY(2), .STARVE_LIMIT(4)) u_dut (
        .clk(clk), .reset(reset), .bus(b));
    memory_bus_arbiter #(.MEM_LATENCY(1), .STARVE_LIMIT(4)) u_l1 (
        .clk(clk), .reset(reset), .bus(b1));
    memory_bus_arbiter #(.MEM_LATENCY(15), .STARVE_LIMIT(4)) u_l15 (
        .clk(clk), .reset(reset), .bus(b15));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'hDEAD_BEEF;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    // Memory models: read data is only valid in the single cycle MEM_LATENCY after mem_en
    int cnt0, cnt1, cnt15;
    logic [31:0] dat0, dat1, dat15;
    always @(posedge clk or negedge reset) begin
        if (!reset) cnt0 <= 0;
        else if (b.mem_en && !b.mem_we) begin cnt0 <= 2; dat0 <= mem_val(b.mem_addr); end
        else if (cnt0 > 0) cnt0 <= cnt0 - 1;
    end
    always @(posedge clk or negedge reset) begin
        if (!reset) cnt1 <= 0;
        else if (b1.mem_en && !b1.mem_we) begin cnt1 <= 1; dat1 <= mem_val(b1.mem_addr); end
        else if (cnt1 > 0) cnt1 <= cnt1 - 1;
    end
    always @(posedge clk or negedge reset) begin
        if (!reset) cnt15 <= 0;
        else if (b15.mem_en && !b15.mem_we) begin cnt15 <= 15; dat15 <= mem_val(b15.mem_addr); end
        else if (cnt15 > 0) cnt15 <= cnt15 - 1;
    end
    assign b.mem_rdata   = (cnt0  == 1) ? dat0  : 32'h0BAD_F00D;
    assign b1.mem_rdata  = (cnt1  == 1) ? dat1  : 32'h0BAD_F00D;
    assign b15.mem_rdata = (cnt15 == 1) ? dat15 : 32'h0BAD_F00D;

    task automatic idle_masters();
        b.m0_req = 0; b.m0_addr = 0; b.m0_we = 0; b.m0_be = 0; b.m0_wdata = 0;
        b.m1_req = 0; b.m1_addr = 0; b.m1_we = 0; b.m1_be = 0; b.m1_wdata = 0; b.m1_urgent = 0;
        b1.m0_req = 0; b1.m0_addr = 0; b1.m0_we = 0; b1.m0_be = 0; b1.m0_wdata = 0;
        b1.m1_req = 0; b1.m1_addr = 0; b1.m1_we = 0; b1.m1_be = 0; b1.m1_wdata = 0; b1.m1_urgent = 0;
        b15.m0_req = 0; b15.m0_addr = 0; b15.m0_we = 0; b15.m0_be = 0; b15.m0_wdata = 0;
        b15.m1_req = 0; b15.m1_addr = 0; b15.m1_we = 0; b15.m1_be = 0; b15.m1_wdata = 0; b15.m1_urgent = 0;
    endtask

    task automatic pulse_reset();
        @(negedge clk); reset = 1'b0;
        @(negedge clk); reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2 reset = 1'b0;
        #1;
        n_total++;
        if ({b.busy, b.owner, b.mem_en, b.mem_we, b.m0_ack, b.m1_ack} !== 6'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl: busy/owner/en/we/ack0/ack1=%b want 000000",
                     {b.busy, b.owner, b.mem_en, b.mem_we, b.m0_ack, b.m1_ack});
        end
        n_total++;
        if ({b.mem_addr, b.mem_be, b.mem_wdata, b.m0_rdata, b.m1_rdata} !== 132'b0) begin
            n_bad++;
            $display("FAIL reset_data: addr=%h be=%h wdata=%h rd0=%h rd1=%h want all 0",
                     b.mem_addr, b.mem_be, b.mem_wdata, b.m0_rdata, b.m1_rdata);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_m0_read();
        exp_t e;
        bit   done = 0;
        e = '{inst: 0, master: 1'b0, addr: 32'h100, rdata: 32'hDEAD_BEEF, chk_rdata: 1'b1, cyc: 4};
        sb.push_back(e);
        @(negedge clk);
        b.m0_addr = 32'h100; b.m0_we = 1'b0; b.m0_be = 4'hF; b.m0_req = 1'b1;
        for (int k = 1; k <= 30 && !done; k++) begin
            @(negedge clk);
            if (k == 1) begin
                n_total++;
                if (b.mem_en !== 1'b1 || b.mem_we !== 1'b0 || b.mem_addr !== 32'h100) begin
                    n_bad++;
                    $display("FAIL read_issue: en=%b we=%b addr=%h want en=1 we=0 addr=00000100",
                             b.mem_en, b.mem_we, b.mem_addr);
                end
            end
            if (k == 2) begin
                n_total++;
                if (b.mem_en !== 1'b0 || b.busy !== 1'b1) begin
                    n_bad++;
                    $display("FAIL read_wait: en=%b busy=%b want en=0 busy=1", b.mem_en, b.busy);
                end
            end
            if (b.m0_ack === 1'b1 || b.m1_ack === 1'b1) begin
                e = sb.pop_front();
                b.m0_req = 1'b0;
                done = 1;
                n_total++;
                if (b.m0_ack !== 1'b1 || k != e.cyc) begin
                    n_bad++;
                    $display("FAIL read_ack: m0_ack=%b cycle=%0d want m0_ack=1 cycle=%0d", b.m0_ack, k, e.cyc);
                end
                n_total++;
                if (b.m0_rdata !== e.rdata || b.m1_rdata !== 32'h0) begin
                    n_bad++;
                    $display("FAIL read_data: rd0=%h rd1=%h want rd0=%h rd1=00000000",
                             b.m0_rdata, b.m1_rdata, e.rdata);
                end
            end
        end
        if (!done) begin
            n_total++; n_bad++; sb.delete();
            $display("FAIL read_timeout: no ack within 30 cycles");
        end
    endtask

    task automatic test_m0_write();
        exp_t e;
        bit   done = 0;
        e = '{inst: 0, master: 1'b0, addr: 32'h40, rdata: 32'h0, chk_rdata: 1'b0, cyc: 2};
        sb.push_back(e);
        @(negedge clk);
        b.m0_addr = 32'h40; b.m0_we = 1'b1; b.m0_be = 4'hF; b.m0_wdata = 32'h1234_5678; b.m0_req = 1'b1;
        for (int k = 1; k <= 30 && !done; k++) begin
            @(negedge clk);
            if (k == 1) begin
                n_total++;
                if ({b.mem_en, b.mem_we, b.mem_be} !== 6'b11_1111 || b.mem_wdata !== 32'h1234_5678 ||
                    b.mem_addr !== 32'h40) begin
                    n_bad++;
                    $display("FAIL write_issue: en=%b we=%b be=%h addr=%h wdata=%h want 1 1 f 00000040 12345678",
                             b.mem_en, b.mem_we, b.mem_be, b.mem_addr, b.mem_wdata);
                end
            end
            if (b.m0_ack === 1'b1 || b.m1_ack === 1'b1) begin
                e = sb.pop_front();
                b.m0_req = 1'b0;
                done = 1;
                n_total++;
                if (b.m0_ack !== 1'b1 || k != e.cyc || b.m0_rdata !== 32'hDEAD_BEEF) begin
                    n_bad++;
                    $display("FAIL write_ack: m0_ack=%b cycle=%0d rd0=%h want 1 cycle=%0d rd0=deadbeef",
                             b.m0_ack, k, b.m0_rdata, e.cyc);
                end
            end
        end
        if (!done) begin
            n_total++; n_bad++; sb.delete();
            $display("FAIL write_timeout: no ack within 30 cycles");
        end
        b.m0_we = 1'b0;
    endtask

    task automatic test_reset_mid_wait();
        exp_t e;
        int   acks = 0;
        bit   done = 0;
        @(negedge clk);
        b.m0_addr = 32'h200; b.m0_we = 1'b0; b.m0_req = 1'b1;
        repeat (2) @(negedge clk);          // now in WAIT
        #2 reset = 1'b0;
        #1;
        n_total++;
        if ({b.busy, b.owner, b.mem_en, b.m0_ack, b.m1_ack} !== 5'b0 ||
            {b.mem_addr, b.m0_rdata, b.m1_rdata} !== 96'b0) begin
            n_bad++;
            $display("FAIL async_reset: busy=%b owner=%b en=%b addr=%h rd0=%h want all 0",
                     b.busy, b.owner, b.mem_en, b.mem_addr, b.m0_rdata);
        end
        b.m0_req = 1'b0;
        @(negedge clk); reset = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (b.m0_ack === 1'b1 || b.m1_ack === 1'b1) acks++;
        end
        n_total++;
        if (acks != 0) begin
            n_bad++;
            $display("FAIL stale_ack: acks=%0d want 0", acks);
        end
        // fresh read after release
        e = '{inst: 0, master: 1'b0, addr: 32'h180, rdata: mem_val(32'h180), chk_rdata: 1'b1, cyc: 4};
        sb.push_back(e);
        b.m0_addr = 32'h180; b.m0_req = 1'b1;
        for (int k = 1; k <= 30 && !done; k++) begin
            @(negedge clk);
            if (b.m0_ack === 1'b1 || b.m1_ack === 1'b1) begin
                e = sb.pop_front();
                b.m0_req = 1'b0;
                done = 1;
                n_total++;
                if (b.m0_ack !== 1'b1 || k != e.cyc || b.m0_rdata !== e.rdata) begin
                    n_bad++;
                    $display("FAIL fresh_read: m0_ack=%b cycle=%0d rd0=%h want 1 cycle=%0d rd0=%h",
                             b.m0_ack, k, b.m0_rdata, e.cyc, e.rdata);
                end
            end
        end
        if (!done) begin
            n_total++; n_bad++; sb.delete();
            $display("FAIL fresh_timeout: no ack within 30 cycles");
        end
    endtask

    task automatic test_round_robin();
        exp_t e;
        bit   pat [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        int   got = 0;
        pulse_reset();
        foreach (pat[i]) begin
            e = '{inst: 0, master: pat[i], addr: pat[i] ? 32'h2000 : 32'h1000,
                  rdata: 32'h0, chk_rdata: 1'b0, cyc: -1};
            sb.push_back(e);
        end
        b.m0_addr = 32'h1000; b.m0_we = 1'b1; b.m0_be = 4'h3; b.m0_wdata = 32'hAAAA_0000;
        b.m1_addr = 32'h2000; b.m1_we = 1'b1; b.m1_be = 4'hC; b.m1_wdata = 32'h0000_BBBB;
        b.m1_urgent = 1'b0; b.m0_req = 1'b1; b.m1_req = 1'b1;
        for (int k = 1; k <= 100 && got < 6; k++) begin
            @(negedge clk);
            if (b.mem_en === 1'b1 && sb.size() > 0) begin
                n_total++;
                if (b.mem_addr !== sb[0].addr) begin
                    n_bad++;
                    $display("FAIL rr_addr[%0d]: addr=%h want %h", got, b.mem_addr, sb[0].addr);
                end
            end
            if (b.m0_ack === 1'b1 || b.m1_ack === 1'b1) begin
                e = sb.pop_front();
                n_total++;
                if ({b.m0_ack, b.m1_ack} !== {~e.master, e.master} || b.owner !== e.master) begin
                    n_bad++;
                    $display("FAIL rr_grant[%0d]: ack0=%b ack1=%b owner=%b want master %0d",
                             got, b.m0_ack, b.m1_ack, b.owner, e.master);
                end
                got++;
                if (got == 6) begin b.m0_req = 1'b0; b.m1_req = 1'b0; end
            end
        end
        if (got < 6) begin
            n_total++; n_bad++; sb.delete(); b.m0_req = 1'b0; b.m1_req = 1'b0;
            $display("FAIL rr_timeout: acks=%0d want 6", got);
        end
    endtask

    task automatic test_urgent_starve();
        exp_t e;
        bit   pat [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        int   got = 0;
        repeat (2) @(negedge clk);
        pulse_reset();
        foreach (pat[i]) begin
            e = '{inst: 0, master: pat[i], addr: pat[i] ? 32'h3000 : 32'h1004,
                  rdata: 32'h0, chk_rdata: 1'b0, cyc: -1};
            sb.push_back(e);
        end
        b.m0_addr = 32'h1004; b.m1_addr = 32'h3000; b.m0_we = 1'b1; b.m1_we = 1'b1;
        b.m1_urgent = 1'b1; b.m0_req = 1'b1; b.m1_req = 1'b1;
        for (int k = 1; k <= 150 && got < 10; k++) begin
            @(negedge clk);
            if (b.mem_en === 1'b1 && sb.size() > 0) begin
                n_total++;
                if (b.mem_addr !== sb[0].addr) begin
                    n_bad++;
                    $display("FAIL urg_addr[%0d]: addr=%h want %h", got, b.mem_addr, sb[0].addr);
                end
            end
            if (b.m0_ack === 1'b1 || b.m1_ack === 1'b1) begin
                e = sb.pop_front();
                n_total++;
                if ({b.m0_ack, b.m1_ack} !== {~e.master, e.master} || b.owner !== e.master) begin
                    n_bad++;
                    $display("FAIL urg_grant[%0d]: ack0=%b ack1=%b owner=%b want master %0d",
                             got, b.m0_ack, b.m1_ack, b.owner, e.master);
                end
                got++;
                if (got == 10) begin b.m0_req = 1'b0; b.m1_req = 1'b0; b.m1_urgent = 1'b0; end
            end
        end
        if (got < 10) begin
            n_total++; n_bad++; sb.delete(); b.m0_req = 1'b0; b.m1_req = 1'b0;
            $display("FAIL urg_timeout: acks=%0d want 10", got);
        end
    endtask

    task automatic test_latency_extremes();
        exp_t e;
        int   busy_err1 = 0, busy_err15 = 0, got = 0;
        e = '{inst: 1, master: 1'b0, addr: 32'h300, rdata: mem_val(32'h300), chk_rdata: 1'b1, cyc: 3};
        sb.push_back(e);
        e = '{inst: 2, master: 1'b0, addr: 32'h304, rdata: mem_val(32'h304), chk_rdata: 1'b1, cyc: 17};
        sb.push_back(e);
        @(negedge clk);
        b1.m0_addr = 32'h300; b1.m0_we = 1'b0; b1.m0_req = 1'b1;
        b15.m0_addr = 32'h304; b15.m0_we = 1'b0; b15.m0_req = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            if (b1.busy !== (k <= 3)) busy_err1++;
            if (b15.busy !== (k <= 17)) busy_err15++;
            if (b1.m0_ack === 1'b1 || b15.m0_ack === 1'b1) begin
                if (sb.size() == 0) begin
                    n_total++; n_bad++;
                    $display("FAIL lat_extra_ack: cycle=%0d want no ack", k);
                end else begin
                    e = sb.pop_front();
                    got++;
                    n_total++;
                    if (e.inst == 1 ? (b1.m0_ack !== 1'b1 || b1.m0_rdata !== e.rdata)
                                    : (b15.m0_ack !== 1'b1 || b15.m0_rdata !== e.rdata) || k != e.cyc) begin
                        n_bad++;
                        $display("FAIL lat_ack_inst%0d: cycle=%0d rd=%h/%h want cycle=%0d rd=%h",
                                 e.inst, k, b1.m0_rdata, b15.m0_rdata, e.cyc, e.rdata);
                    end
                    if (k != e.cyc && e.inst == 1) begin
                        n_total++; n_bad++;
                        $display("FAIL lat1_cycle: cycle=%0d want %0d", k, e.cyc);
                    end
                end
                if (b1.m0_ack === 1'b1) b1.m0_req = 1'b0;
                if (b15.m0_ack === 1'b1) b15.m0_req = 1'b0;
            end
        end
        n_total++;
        if (got != 2) begin
            n_bad++; sb.delete();
            $display("FAIL lat_acks: got=%0d want 2", got);
        end
        n_total++;
        if (busy_err1 != 0 || busy_err15 != 0) begin
            n_bad++;
            $display("FAIL lat_busy: errors lat1=%0d lat15=%0d want 0 0", busy_err1, busy_err15);
        end
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        idle_masters();
        test_reset();
        test_m0_read();
        test_m0_write();
        test_reset_mid_wait();
        test_round_robin();
        test_urgent_starve();
        test_latency_extremes();
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    // Hard stop in case a task wedges on a missing clock edge
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "global timeout");
    end

endmodule
`default_nettype wire
